axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Two-master AXI4 read-channel arbiter that shares the single 64-bit AXI-full memory read port between the instruction cache (master 0) and the data cache (master 1). Accepts one AR request at a time, buffers it, issues it downstream, then routes the whole R burst back to the granted master before re-arbitrating. Sits between the two cache refill engines and the memory-side AXI slave.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, master 1 (dcache) wins ties

Ports (mN = m0 icache, m1 dcache; both masters have identical port sets):
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mN_araddr  in  32  read address
- mN_arvalid  in  1  address valid
- mN_arburst  in  2  burst type (01 INCR expected)
- mN_arlen  in  8  beats minus one
- mN_arsize  in  3  beat size (3 = 8 B)
- mN_arready  out  1  address accepted by arbiter
- mN_rdata  out  64  read data
- mN_rresp  out  2  read response
- mN_rvalid  out  1  data valid
- mN_rlast  out  1  last beat
- mN_rready  in  1  master accepts data
- s_araddr/s_arburst/s_arlen/s_arsize  out  32/2/8/3  downstream AR fields
- s_arvalid  out  1  downstream address valid
- s_arready  in  1  slave accepts address
- s_rdata  in  64,  s_rresp  in  2,  s_rvalid  in  1,  s_rlast  in  1
- s_rready  out  1  arbiter accepts data
- beat_err  out  1  one-cycle pulse: burst length mismatch

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: if any mN_arvalid, pick winner; assert winner's mN_arready combinationally in the same cycle; latch its AR fields into ar_q, set gnt, go ADDR. Loser's arready = 0.
- Arbitration: RR_EN=1 → if both request, grant the master not in last_gnt; single requester always wins. RR_EN=0 → m1 wins ties.
- ADDR: s_arvalid = 1, s_ar* = ar_q (stable until handshake). On s_arvalid & s_arready: clear beat counter, go DATA.
- DATA: combinational route. Granted master: mN_rdata/rresp/rlast = s_*, mN_rvalid = s_rvalid; s_rready = granted mN_rready. Non-granted master: rvalid=0, rlast=0, rdata/rresp driven 0. Beat counter (8-bit) increments on each s_rvalid & s_rready.
- On handshake with s_rlast=1: last_gnt ← gnt, go IDLE.
- beat_err pulses (registered, 1 cycle after beat) if s_rlast on a beat with count ≠ ar_q.arlen, or count = ar_q.arlen without s_rlast (burst then continues until s_rlast).
- mN_arready is 0 in ADDR and DATA: no outstanding second request; new AR waits in master.
- arburst/arsize passed through unmodified; no checking.

## Timing
- Reset (async assert, sync-free release): state IDLE, last_gnt = 1 (m0 wins first tie), ar_q = 0, beat counter 0, gnt = 0, s_arvalid = 0, beat_err = 0; all mN_arready/rvalid/rlast = 0, s_rready = 0.
- Request latency: mN_arvalid&arready at cycle t → s_arvalid=1 at t+1.
- s_arready held high at t+1 → DATA at t+2; first beat may be forwarded in t+2 with zero added latency (R path combinational).
- Last-beat handshake at cycle u → IDLE at u+1; next grant possible at u+1 (new arready in u+1).
- Back-to-back from same master with other idle: allowed, one bubble cycle (IDLE) between bursts.
- Reset mid-ADDR or mid-DATA: all outputs fall immediately; in-flight burst abandoned (slave reset together).
- mN_arvalid dropped before grant: ignored, no state change.

## Structure
- Shared package axi_pkg: burst encodings (BURST_INCR = 2'b01), AR field struct (addr, burst, len, size), RESP_OKAY.
- Sub-module rr_arb2: 2-way arbiter (req[1:0], last_gnt, RR_EN → one-hot gnt), purely combinational, reusable for future write arbiter.

## Test plan
- Single m0 request araddr=0x8000_0000, arlen=3 → s_araddr=0x8000_0000 one cycle after accept; four beats routed to m0 only, m0_rlast on beat 4, m1_rvalid stays 0.
- Simultaneous m0/m1 requests after reset, RR_EN=1 → m0 granted first, m1 second; repeat tie → m0 again (alternation).
- Same tie with RR_EN=0 → m1 granted both times.
- m1 requests while m0 burst (arlen=7) active → m1_arready stays 0 until m0 last beat; m1 granted cycle after.
- s_rready backpressure: m0_rready low for 3 cycles mid-burst → s_rready low same cycles, no beat lost or duplicated.
- Slave asserts s_rlast on beat 2 of arlen=3 → beat_err pulses once, arbiter returns IDLE; async rst during DATA → all valids 0 immediately, next request served normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory-side read path.
//   BURST_*   : AxBURST encodings
//   RESP_*    : xRESP encodings
//   ar_req_t  : buffered AR channel fields (addr, burst, len, size)
//   rd_state_e: read arbiter sequencing states
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_req_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter.
//   RR_EN    : 1 = round-robin on ties, 0 = fixed priority (req[1] wins ties)
//   req      : request vector, bit N = master N
//   last_gnt : index of the master granted most recently
//   gnt      : one-hot grant, all-zero when nothing requests
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie, round-robin hands the grant to whoever did not have it last.
      2'b11:   gnt = (RR_EN && last_gnt) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: icache (m0) and dcache (m1) share one 64-bit
// memory read port. One AR is accepted, buffered and issued downstream; the
// whole R burst is then routed back to the granted master before re-arbitration.
//   clk, rst          : clock, asynchronous active-high reset
//   mN_ar*            : master AR channels (arready asserted combinationally in IDLE)
//   mN_r*             : master R channels (combinationally routed from s_r*)
//   s_ar*             : downstream AR channel driven from the buffered request
//   s_r*              : downstream R channel
//   beat_err          : one-cycle pulse when s_rlast disagrees with the beat count
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (icache)
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  input  logic [1:0]  m0_arburst,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  output logic [63:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  input  logic        m0_rready,
  // master 1 (dcache)
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  input  logic [1:0]  m1_arburst,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic [63:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  input  logic        m1_rready,
  // downstream slave
  output logic [31:0] s_araddr,
  output logic [1:0]  s_arburst,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [63:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  input  logic        s_rlast,
  output logic        s_rready,
  output logic        beat_err
);

  rd_state_e  state_q, state_d;
  ar_req_t    ar_q, ar_d;
  logic       gnt_q, gnt_d;            // index of the master owning the current burst
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat_err_q, beat_err_d;

  logic [1:0] req;
  logic [1:0] arb_gnt;
  ar_req_t    m0_ar, m1_ar;

  assign req   = {m1_arvalid, m0_arvalid};
  assign m0_ar = {m0_araddr, m0_arburst, m0_arlen, m0_arsize};
  assign m1_ar = {m1_araddr, m1_arburst, m1_arlen, m1_arsize};

  rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt)
  );

  // The buffered request drives the slave AR fields in every state; only
  // s_arvalid qualifies them.
  assign s_araddr  = ar_q.addr;
  assign s_arburst = ar_q.burst;
  assign s_arlen   = ar_q.len;
  assign s_arsize  = ar_q.size;
  assign beat_err  = beat_err_q;

  always_comb begin
    state_d    = state_q;
    ar_d       = ar_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    beat_err_d = 1'b0;

    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m0_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_rlast   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so arready stays low while reset is held.
        if (!rst && (req != 2'b00)) begin
          m0_arready = arb_gnt[0];
          m1_arready = arb_gnt[1];
          ar_d       = arb_gnt[1] ? m1_ar : m0_ar;
          gnt_d      = arb_gnt[1];
          state_d    = StAddr;
        end
      end

      StAddr: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end

      StData: begin
        if (gnt_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
          m1_rlast  = s_rlast;
          s_rready  = m1_rready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
          m0_rlast  = s_rlast;
          s_rready  = m0_rready;
        end

        if (s_rvalid && s_rready) begin
          cnt_d = cnt_q + 8'd1;
          // Flags both an early s_rlast and a missing one on the expected last
          // beat; the burst itself always runs until s_rlast.
          beat_err_d = s_rlast ^ (cnt_q == ar_q.len);
          if (s_rlast) begin
            last_gnt_d = gnt_q;
            state_d    = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ar_q       <= '0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;   // m0 wins the first tie after reset
      cnt_q      <= '0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_q       <= ar_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

endmodule
